// File: rtl/uart_tx_pkg.sv
// Shared constants and helpers for the UART TX datapath.
// Parity encoding is used only when UART_SER_PARITY_EN is defined.
package uart_tx_pkg;

  localparam int DATA_WIDTH_DEF = 8;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Minimum bit-counter width able to index the last data bit.
  function automatic int cnt_width(input int data_width);
    return (data_width > 1) ? $clog2(data_width) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_parity_calc.sv
// Frame parity generator: XOR-reduces the parallel word and registers the
// result at load. Instantiated only when UART_SER_PARITY_EN is defined.
module uart_tx_parity_calc
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  par_bit
);

  logic even_par;

  assign even_par = ^data;

  always_ff @(posedge CLK) begin
    if (RST) begin
      par_bit <= 1'b0;
    end else if (load) begin
      par_bit <= (par_typ == PAR_ODD) ? ~even_par : even_par;
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART TX data serializer: captures a word while the link is idle and shifts
// it out LSB-first on ser_en. Optional parity port under UART_SER_PARITY_EN.
module uart_tx_serializer
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  busy,
  input  logic                  ser_en,
  output logic                  ser_data,
  output logic                  ser_done,
  output logic                  data_dropped
`ifdef UART_SER_PARITY_EN
  ,
  input  logic                  PAR_TYP,
  output logic                  par_bit
`endif
);

  localparam logic [CNT_WIDTH-1:0] LAST_BIT = CNT_WIDTH'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] shift_reg;
  logic [CNT_WIDTH-1:0]  bit_cnt;
  logic                  loaded;
  logic                  load;

  assign load = Data_Valid && !busy;

  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments so every register samples the pre-edge
    // value of the others, independent of statement order.
    if (RST) begin
      shift_reg    <= '0;
      bit_cnt      <= '0;
      loaded       <= 1'b0;
      data_dropped <= 1'b0;
    end else begin
      data_dropped <= Data_Valid && busy;
      if (load) begin
        shift_reg <= P_DATA;
        bit_cnt   <= '0;
        loaded    <= 1'b1;
      end else if (ser_en && loaded && (bit_cnt < LAST_BIT)) begin
        // Counter saturates on the last bit so it stays on the line.
        shift_reg <= shift_reg >> 1;
        bit_cnt   <= bit_cnt + 1'b1;
      end
    end
  end

  assign ser_data = shift_reg[0];
  assign ser_done = loaded && (bit_cnt == LAST_BIT);

`ifdef UART_SER_PARITY_EN
  uart_tx_parity_calc #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_parity (
    .CLK     (CLK),
    .RST     (RST),
    .load    (load),
    .data    (P_DATA),
    .par_typ (PAR_TYP),
    .par_bit (par_bit)
  );
`endif

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: directed frames then random
// traffic, compared against a word/index reference model.
module tb_uart_tx_serializer;

  localparam int DW = 8;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic [DW-1:0] P_DATA = '0;
  logic          Data_Valid = 1'b0;
  logic          busy = 1'b0;
  logic          ser_en = 1'b0;
  logic          ser_data;
  logic          ser_done;
  logic          data_dropped;
`ifdef UART_SER_PARITY_EN
  logic          PAR_TYP = 1'b0;
  logic          par_bit;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: the captured word and how many bits have been sent.
  logic [DW-1:0] m_word   = '0;
  int            m_idx    = 0;
  logic          m_loaded = 1'b0;
  logic          m_drop   = 1'b0;
  logic          m_par    = 1'b0;

  uart_tx_serializer #(
    .DATA_WIDTH (DW),
    .CNT_WIDTH  (4)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .P_DATA       (P_DATA),
    .Data_Valid   (Data_Valid),
    .busy         (busy),
    .ser_en       (ser_en),
    .ser_data     (ser_data),
    .ser_done     (ser_done),
    .data_dropped (data_dropped)
`ifdef UART_SER_PARITY_EN
    ,
    .PAR_TYP      (PAR_TYP),
    .par_bit      (par_bit)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic par_typ_s;
`ifdef UART_SER_PARITY_EN
    par_typ_s = PAR_TYP;
`else
    par_typ_s = 1'b0;
`endif
    if (RST) begin
      m_word = '0; m_idx = 0; m_loaded = 1'b0; m_drop = 1'b0; m_par = 1'b0;
    end else begin
      m_drop = Data_Valid && busy;
      if (Data_Valid && !busy) begin
        m_word = P_DATA; m_idx = 0; m_loaded = 1'b1;
        m_par = (^P_DATA) ^ par_typ_s;
      end else if (ser_en && m_loaded && m_idx < DW - 1) begin
        m_idx++;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    logic exp_data;
    exp_data = m_loaded ? m_word[m_idx] : 1'b0;
    check({tag, ".ser_data"}, ser_data, exp_data);
    check({tag, ".ser_done"}, ser_done, m_loaded && (m_idx == DW - 1));
    check({tag, ".data_dropped"}, data_dropped, m_drop);
`ifdef UART_SER_PARITY_EN
    check({tag, ".par_bit"}, par_bit, m_par);
`endif
  endtask

  // One clock: model follows the edge, outputs sampled 1 time unit later.
  task automatic step(input string tag);
    @(posedge CLK);
    model_edge();
    #1;
    compare_all(tag);
  endtask

  task automatic drive(input logic rst, input logic [DW-1:0] d, input logic dv,
                       input logic b, input logic en);
    RST = rst; P_DATA = d; Data_Valid = dv; busy = b; ser_en = en;
  endtask

  initial begin
    logic [7:0] a5_bits;

    // Reset, then idle.
    drive(1'b1, '0, 1'b0, 1'b0, 1'b0);
    step("reset");
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step("idle");

    // 0xA5 frame: bit 0 visible right after load, then 8 ser_en cycles.
    drive(1'b0, 8'hA5, 1'b1, 1'b0, 1'b0);
    step("load_a5");
    a5_bits = 8'hA5;
    check("a5_bit0_const", ser_data, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b1, 1'b1);
    for (int k = 1; k < DW; k++) begin
      step("shift_a5");
      check("a5_bit_const", ser_data, a5_bits[k]);
      check("a5_done_const", ser_done, k == DW - 1);
    end
    // Saturation: extra ser_en cycles hold the last bit and ser_done.
    for (int i = 0; i < 3; i++) begin
      step("saturate");
      check("sat_data_const", ser_data, 1'b1);
      check("sat_done_const", ser_done, 1'b1);
    end
    drive(1'b0, 8'h3C, 1'b1, 1'b0, 1'b0);
    step("load_3c");
    check("3c_done_const", ser_done, 1'b0);
    check("3c_data_const", ser_data, 1'b0);

    // Drop while busy during a 0x00 frame.
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step("load_00");
    drive(1'b0, '0, 1'b0, 1'b1, 1'b1);
    step("shift_00");
    drive(1'b0, 8'hFF, 1'b1, 1'b1, 1'b1);
    step("drop_edge");
    check("drop_pulse_const", data_dropped, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < DW; i++) begin
      step("after_drop");
      check("after_drop_data_const", ser_data, 1'b0);
      check("after_drop_pulse_const", data_dropped, 1'b0);
    end

    // Reset mid-frame of 0xF0, then ser_en without a load.
    drive(1'b0, 8'hF0, 1'b1, 1'b0, 1'b0);
    step("load_f0");
    drive(1'b0, '0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step("shift_f0");
    check("f0_bit4_const", ser_data, 1'b1);
    drive(1'b1, '0, 1'b0, 1'b1, 1'b1);
    step("mid_reset");
    check("mid_reset_done_const", ser_done, 1'b0);
    check("mid_reset_data_const", ser_data, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < DW + 2; i++) step("en_no_load");

`ifdef UART_SER_PARITY_EN
    drive(1'b0, 8'h07, 1'b1, 1'b0, 1'b0); PAR_TYP = 1'b0;
    step("par_07_even");
    check("par_07_even_const", par_bit, 1'b1);
    PAR_TYP = 1'b1;
    step("par_07_odd");
    check("par_07_odd_const", par_bit, 1'b0);
    P_DATA = 8'h00;
    step("par_00_odd");
    check("par_00_odd_const", par_bit, 1'b1);
    Data_Valid = 1'b0;
`endif

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 39) == 0), DW'($urandom),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 3) != 0));
`ifdef UART_SER_PARITY_EN
      PAR_TYP = 1'($urandom);
`endif
      step("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- Datapath stage directly downstream of the UART TX control FSM.
- Captures a parallel word when the link is idle, then shifts it out LSB-first, one bit per `ser_en` cycle.
- Raises `ser_done` while the last data bit is on the line, so the FSM can move to parity or stop.
- Its `ser_data` output feeds the TX output mux data leg.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame; legal range 5..9.
- CNT_WIDTH, 4, bit-counter width; must be at least clog2(DATA_WIDTH).

Ports:
- CLK  input  1  system clock; all state updates on its rising edge.
- RST  input  1  synchronous, active-high reset.
- P_DATA  input  DATA_WIDTH  parallel frame data.
- Data_Valid  input  1  P_DATA qualifier.
- busy  input  1  TX FSM busy flag; high from start bit through stop bit.
- ser_en  input  1  shift enable from the TX FSM; high only during data-bit cycles.
- ser_data  output  1  current serial data bit.
- ser_done  output  1  last data bit is presented on ser_data.
- data_dropped  output  1  one-cycle pulse when Data_Valid is seen while busy=1.

Interface decision: one clock (CLK); reset RST is synchronous and active-high.

Behaviour:
- Reset (RST=1 at CLK edge):
  - shift_reg=0, bit_cnt=0, loaded=0, data_dropped=0.
  - Hence ser_data=0 and ser_done=0.
  - Reset wins over every other event in the same cycle, including mid-frame.
- Load: Data_Valid=1 and busy=0 at an edge:
  - shift_reg<=P_DATA, bit_cnt<=0, loaded<=1.
  - Load has priority over shift when both occur in the same cycle.
- Ignore: Data_Valid=1 and busy=1:
  - No load; shift_reg is unchanged.
  - data_dropped=1 for exactly the next cycle.
- ser_data is combinational from shift_reg[0]. There is no output register, so a bit appears the cycle after its shift.
- Shift: ser_en=1, loaded=1, bit_cnt<DATA_WIDTH-1:
  - shift_reg<=shift_reg>>1 with MSB filled with 0.
  - bit_cnt<=bit_cnt+1.
- Last bit:
  - ser_done = loaded && (bit_cnt==DATA_WIDTH-1), combinational.
  - Data bit k is on ser_data during the k-th ser_en cycle (k=0..DATA_WIDTH-1).
  - ser_done is high exactly during ser_en cycle DATA_WIDTH-1.
- Saturation:
  - ser_en=1 at bit_cnt==DATA_WIDTH-1 causes no shift and no increment.
  - ser_data holds the last bit and ser_done stays high until the next load or reset.
- ser_en=1 with loaded=0: no effect; ser_done stays 0.
- ser_en=0: all state holds.
- Latency: load edge to bit0 on ser_data is 0 cycles. Word to ser_done is DATA_WIDTH-1 ser_en cycles after the first.

Optional Feature:
- Macro: UART_SER_PARITY_EN.
- When defined:
  - Adds input PAR_TYP (1: 0=even, 1=odd) and output par_bit (1).
  - par_bit is registered at load: even gives XOR-reduce(P_DATA); odd gives its inverse.
  - par_bit is reset to 0 and holds until the next load.
  - PAR_TYP is sampled only at load.
- When undefined: neither port exists and there is no parity logic.

Decomposition:
- Package uart_tx_pkg:
  - DATA_WIDTH default.
  - PAR_EVEN=1'b0 and PAR_ODD=1'b1 constants.
  - Counter-width function.
- Sub-module: uart_tx_parity_calc (combinational reduce plus load register), instantiated only under UART_SER_PARITY_EN.

Test Plan:
- RST=1, then idle for 5 cycles -> ser_data=0, ser_done=0, data_dropped=0.
- P_DATA=0xA5, Data_Valid=1, busy=0, then ser_en for 8 cycles -> ser_data=1,0,1,0,0,1,0,1; ser_done high only in cycle 8.
- Hold ser_en=1 for 3 extra cycles after the last bit -> ser_data stays 1, ser_done stays 1. Then load 0x3C -> ser_done=0, ser_data=0.
- busy=1 with Data_Valid=1 and P_DATA=0xFF during a shift of 0x00 -> data_dropped pulses once; ser_data stays 0 for the remaining bits.
- RST=1 at bit 4 of 0xF0 -> next cycle ser_done=0, ser_data=0. ser_en with no load -> no change.
- UART_SER_PARITY_EN: 0x07 with PAR_TYP=0 -> par_bit=1; with PAR_TYP=1 -> par_bit=0. 0x00 with PAR_TYP=1 -> par_bit=1.
